// File: rtl/precision_adj_nch.sv
// precision_adj_nch -- N-channel gain / precision adjust stage.
//
// Each channel sample is multiplied by a per-channel unsigned fixed-point
// coefficient (FRAC fractional bits). The product is shifted back by FRAC,
// optionally rounded, and saturated to DW bits. The sync enable and the bin
// counter travel alongside, so every output is exactly 4 cycles behind its
// input.
//
// Coefficients are double-buffered. Writes land in a shadow bank. A commit
// arms a transfer into the active bank, and that transfer happens only at the
// next frame start (en_sync_in=1 with cnt_sync_in==0). This way a spectrum
// never mixes old and new gains.
//
// Optional build macro: PRECISION_ADJ_ROUND_EN
//   defined   : round-half-up (add 2^(FRAC-1) before the shift)
//   undefined : plain arithmetic shift (floor)
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   coef_wr/addr/data  shadow coefficient write (addr >= NCH ignored)
//   coef_commit     arm shadow->active transfer at next frame start
//   commit_pending  transfer armed but not yet applied
//   en_sync_in/out  sample-valid, delayed by 4
//   cnt_sync_in/out bin counter, delayed by 4
//   data_in/out     NCH x DW packed samples, channel n at [n*DW +: DW]
//   sat_flag        sticky per-channel saturation flags
//   sat_clr         clear all sat_flag bits (a simultaneous set wins)

// Per-channel datapath: S1 capture, S2 multiply, S3 shift/round,
// S4 saturate and register.
module precision_adj_lane #(
   parameter int DW   = 16,
   parameter int CW   = 16,
   parameter int FRAC = 8,
   parameter bit SGN  = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] din,
   input  logic [CW-1:0] coef,
   output logic [DW-1:0] dout,
   output logic          clamp
);
   localparam int PW = DW + CW + 1;   // full product width
   localparam int RW = PW - FRAC;     // width after the shift
`ifdef PRECISION_ADJ_ROUND_EN
   localparam logic signed [PW-1:0] HALF = PW'(1) << (FRAC - 1);
`endif
   localparam logic signed [RW-1:0] UMAX = {{(RW-DW){1'b0}}, {DW{1'b1}}};
   localparam logic signed [RW-1:0] SMAX = {{(RW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [RW-1:0] SMIN = {{(RW-DW+1){1'b1}}, {(DW-1){1'b0}}};

   logic        [DW-1:0] d1;
   logic        [CW-1:0] c1;
   logic signed [PW-1:0] dx, cx, p2, rnd;
   logic signed [RW-1:0] r3;
   logic        [DW-1:0] sat_val;

   // Both operands are widened to the product width. A signed sample gets
   // sign extension and the coefficient is always zero-extended. The
   // multiply is then exact for both channel kinds.
   always_comb begin
      dx = {{(PW-DW){SGN & d1[DW-1]}}, d1};
      cx = {{(PW-CW){1'b0}}, c1};
   end

   always_comb begin
`ifdef PRECISION_ADJ_ROUND_EN
      rnd = p2 + HALF;
`else
      rnd = p2;
`endif
   end

   always_comb begin
      sat_val = r3[DW-1:0];
      clamp   = 1'b0;
      if (SGN) begin
         if (r3 > SMAX) begin
            sat_val = SMAX[DW-1:0];
            clamp   = 1'b1;
         end else if (r3 < SMIN) begin
            sat_val = SMIN[DW-1:0];
            clamp   = 1'b1;
         end
      end else begin
         // An unsigned product is never negative. The low clamp only
         // keeps the range check complete.
         if (r3 < 0) begin
            sat_val = '0;
            clamp   = 1'b1;
         end else if (r3 > UMAX) begin
            sat_val = UMAX[DW-1:0];
            clamp   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         d1   <= '0;
         c1   <= '0;
         p2   <= '0;
         r3   <= '0;
         dout <= '0;
      end else begin
         d1   <= din;
         c1   <= coef;
         p2   <= dx * cx;
         r3   <= RW'(rnd >>> FRAC);
         dout <= sat_val;
      end
   end
endmodule

module precision_adj_nch #(
   parameter int             NCH         = 4,
   parameter int             DW          = 16,
   parameter int             CW          = 16,
   parameter int             FRAC        = 8,
   parameter int             CNT_W       = 9,
   parameter logic [NCH-1:0] SIGNED_MASK = NCH'(4'b1100),
   localparam int            AW          = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               coef_wr,
   input  logic [AW-1:0]      coef_addr,
   input  logic [CW-1:0]      coef_data,
   input  logic               coef_commit,
   output logic               commit_pending,
   input  logic               en_sync_in,
   input  logic [CNT_W-1:0]   cnt_sync_in,
   input  logic [NCH*DW-1:0]  data_in,
   output logic               en_sync_out,
   output logic [CNT_W-1:0]   cnt_sync_out,
   output logic [NCH*DW-1:0]  data_out,
   output logic [NCH-1:0]     sat_flag,
   input  logic               sat_clr
);
   localparam logic [CW-1:0] UNITY = CW'(1) << FRAC;

   logic [NCH-1:0][CW-1:0]    shadow, active, coef_sel;
   logic [NCH-1:0][DW-1:0]    din_arr, dout_arr;
   logic [NCH-1:0]            clamp;
   logic                      pending, frame_start, apply;
   logic [3:0]                en_pipe;   // [0]=S1 .. [3]=output
   logic [3:0][CNT_W-1:0]     cnt_pipe;

   assign frame_start    = en_sync_in && (cnt_sync_in == '0);
   assign apply          = frame_start && pending;
   assign commit_pending = pending;
   assign din_arr        = data_in;
   assign data_out       = dout_arr;
   assign en_sync_out    = en_pipe[3];
   assign cnt_sync_out   = cnt_pipe[3];

   // On an applying frame start, S1 takes the shadow bank directly, so the
   // boundary sample already uses the new gains. The shadow register still
   // holds its pre-write value in that cycle, so a write on the boundary is
   // not part of this transfer.
   assign coef_sel = apply ? shadow : active;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int n = 0; n < NCH; n++) begin
            shadow[n] <= UNITY;
            active[n] <= UNITY;
         end
         pending <= 1'b0;
      end else begin
         // An address >= NCH matches no channel, so the write is dropped.
         for (int n = 0; n < NCH; n++)
            if (coef_wr && coef_addr == AW'(n))
               shadow[n] <= coef_data;
         if (apply)
            active <= shadow;
         // A commit that arrives with the applying boundary re-arms for the
         // following boundary.
         pending <= apply ? coef_commit : (pending | coef_commit);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         en_pipe  <= '0;
         cnt_pipe <= '0;
         sat_flag <= '0;
      end else begin
         en_pipe  <= {en_pipe[2:0], en_sync_in};
         cnt_pipe <= {cnt_pipe[2:0], cnt_sync_in};
         // en_pipe[2] belongs to the sample that S4 is saturating now.
         sat_flag <= (sat_flag & ~{NCH{sat_clr}}) | (clamp & {NCH{en_pipe[2]}});
      end
   end

   for (genvar n = 0; n < NCH; n++) begin : g_lane
      precision_adj_lane #(
         .DW   (DW),
         .CW   (CW),
         .FRAC (FRAC),
         .SGN  (SIGNED_MASK[n])
      ) u_lane (
         .clk   (clk),
         .rst   (rst),
         .din   (din_arr[n]),
         .coef  (coef_sel[n]),
         .dout  (dout_arr[n]),
         .clamp (clamp[n])
      );
   end
endmodule

// File: tb/tb_precision_adj_nch.sv
// Directed testbench for precision_adj_nch (NCH=4, DW=16, CW=16, FRAC=8).
// Expected values are hand-computed. Rounding expectations follow the
// PRECISION_ADJ_ROUND_EN macro.
module tb_precision_adj_nch;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        coef_wr = 1'b0;
   logic [1:0]  coef_addr = '0;
   logic [15:0] coef_data = '0;
   logic        coef_commit = 1'b0;
   logic        commit_pending;
   logic        en_sync_in = 1'b0;
   logic [8:0]  cnt_sync_in = '0;
   logic [63:0] data_in = '0;
   logic        en_sync_out;
   logic [8:0]  cnt_sync_out;
   logic [63:0] data_out;
   logic [3:0]  sat_flag;
   logic        sat_clr = 1'b0;

   int checks = 0;
   int errors = 0;

   precision_adj_nch dut (
      .clk(clk), .rst(rst), .coef_wr(coef_wr), .coef_addr(coef_addr),
      .coef_data(coef_data), .coef_commit(coef_commit),
      .commit_pending(commit_pending), .en_sync_in(en_sync_in),
      .cnt_sync_in(cnt_sync_in), .data_in(data_in), .en_sync_out(en_sync_out),
      .cnt_sync_out(cnt_sync_out), .data_out(data_out), .sat_flag(sat_flag),
      .sat_clr(sat_clr)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] ch(input int n);
      return data_out[n*16 +: 16];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one sample for one cycle. Any coefficient/commit/clear strobes
   // set beforehand apply to that cycle and are dropped afterwards.
   task automatic push(input logic e, input logic [8:0] c,
                       input logic [15:0] a0, a1, a2, a3);
      en_sync_in  = e;
      cnt_sync_in = c;
      data_in     = {a3, a2, a1, a0};
      tick();
      coef_wr     = 1'b0;
      coef_commit = 1'b0;
      sat_clr     = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) push(1'b0, 9'd1, 16'h0, 16'h0, 16'h0, 16'h0);
   endtask

   task automatic wr(input logic [1:0] a, input logic [15:0] d);
      coef_wr = 1'b1; coef_addr = a; coef_data = d;
      idle(1);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      checks++;
      if ({en_sync_out, cnt_sync_out, data_out, sat_flag, commit_pending} !== '0) begin
         errors++;
         $display("FAIL reset_state got en=%b cnt=%0d data=%h sat=%b pend=%b exp all 0",
                  en_sync_out, cnt_sync_out, data_out, sat_flag, commit_pending);
      end
      rst = 1'b0;
      push(1'b1, 9'd5, 16'd1000, 16'h0, 16'h0, 16'h0);
      idle(2);
      checks++;
      if (en_sync_out !== 1'b0) begin
         errors++;
         $display("FAIL latency_early got en=%b exp 0", en_sync_out);
      end
      idle(1);
      checks++;
      if ({en_sync_out, cnt_sync_out, ch(0)} !== {1'b1, 9'd5, 16'd1000}) begin
         errors++;
         $display("FAIL unity_default got en=%b cnt=%0d ch0=%0d exp en=1 cnt=5 ch0=1000",
                  en_sync_out, cnt_sync_out, ch(0));
      end
      checks++;
      if ({commit_pending, sat_flag} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags got pend=%b sat=%b exp 0", commit_pending, sat_flag);
      end
   endtask

   task automatic test_unsigned_sat();
      wr(2'd0, 16'h0400);
      coef_commit = 1'b1;
      idle(1);
      checks++;
      if (commit_pending !== 1'b1) begin
         errors++;
         $display("FAIL pending_set got %b exp 1", commit_pending);
      end
      push(1'b1, 9'd0, 16'h8000, 16'h0, 16'h0, 16'h0);
      checks++;
      if (commit_pending !== 1'b0) begin
         errors++;
         $display("FAIL pending_clr got %b exp 0", commit_pending);
      end
      idle(3);
      checks++;
      if ({ch(0), sat_flag} !== {16'hFFFF, 4'b0001}) begin
         errors++;
         $display("FAIL usat_clamp got ch0=%h sat=%b exp ffff 0001", ch(0), sat_flag);
      end
      sat_clr = 1'b1;
      idle(1);
      checks++;
      if (sat_flag !== 4'b0) begin
         errors++;
         $display("FAIL sat_clr got %b exp 0000", sat_flag);
      end
      // A clamped sample with en=0 still flows but must not flag.
      push(1'b0, 9'd2, 16'h8000, 16'h0, 16'h0, 16'h0);
      idle(3);
      checks++;
      if ({ch(0), sat_flag} !== {16'hFFFF, 4'b0000}) begin
         errors++;
         $display("FAIL usat_noen got ch0=%h sat=%b exp ffff 0000", ch(0), sat_flag);
      end
      push(1'b1, 9'd1, 16'h1000, 16'h0, 16'h0, 16'h0);
      idle(3);
      checks++;
      if ({ch(0), sat_flag} !== {16'h4000, 4'b0000}) begin
         errors++;
         $display("FAIL ugain_x4 got ch0=%h sat=%b exp 4000 0000", ch(0), sat_flag);
      end
   endtask

   task automatic test_signed();
      wr(2'd3, 16'h0200);
      coef_commit = 1'b1;
      idle(1);
      push(1'b1, 9'd0, 16'h0, 16'h0, 16'h0, 16'hC000);
      push(1'b1, 9'd1, 16'h0, 16'h0, 16'h0, 16'hBFFF);
      push(1'b1, 9'd2, 16'h0, 16'h0, 16'h0, 16'h3FFF);
      idle(1);
      checks++;
      if ({ch(3), sat_flag} !== {16'h8000, 4'b0000}) begin
         errors++;
         $display("FAIL smin_exact got ch3=%h sat=%b exp 8000 0000", ch(3), sat_flag);
      end
      // The clear arrives with the clamping sample, and the set must win.
      sat_clr = 1'b1;
      idle(1);
      checks++;
      if ({ch(3), sat_flag} !== {16'h8000, 4'b1000}) begin
         errors++;
         $display("FAIL smin_clamp got ch3=%h sat=%b exp 8000 1000", ch(3), sat_flag);
      end
      idle(1);
      checks++;
      if (ch(3) !== 16'h7FFE) begin
         errors++;
         $display("FAIL spos_x2 got ch3=%h exp 7ffe", ch(3));
      end
      sat_clr = 1'b1;
      idle(1);
   endtask

   task automatic test_commit_timing();
      logic [8:0] ec;
      wr(2'd1, 16'h0300);
      coef_commit = 1'b1;
      push(1'b1, 9'd100, 16'h0, 16'd10, 16'h0, 16'h0);
      checks++;
      if (commit_pending !== 1'b1) begin
         errors++;
         $display("FAIL commit_armed got %b exp 1", commit_pending);
      end
      for (int c = 101; c < 512; c++) begin
         // A shadow overwrite after the commit is still picked up at the boundary.
         if (c == 200) begin
            coef_wr = 1'b1; coef_addr = 2'd1; coef_data = 16'h0200;
         end
         push(1'b1, 9'(c), 16'h0, 16'd10, 16'h0, 16'h0);
         if (c >= 103) begin
            ec = 9'(c - 3);
            checks++;
            if ({en_sync_out, cnt_sync_out, ch(1)} !== {1'b1, ec, 16'd10}) begin
               errors++;
               $display("FAIL old_gain got en=%b cnt=%0d ch1=%0d exp en=1 cnt=%0d ch1=10",
                        en_sync_out, cnt_sync_out, ch(1), ec);
            end
         end
      end
      // Write on the boundary cycle must wait for the next commit.
      coef_wr = 1'b1; coef_addr = 2'd1; coef_data = 16'h0400;
      push(1'b1, 9'd0, 16'h0, 16'd10, 16'h0, 16'h0);
      checks++;
      if (commit_pending !== 1'b0) begin
         errors++;
         $display("FAIL commit_applied got %b exp 0", commit_pending);
      end
      for (int c = 1; c <= 5; c++) begin
         push(1'b1, 9'(c), 16'h0, 16'd10, 16'h0, 16'h0);
         ec = 9'((c + 509) % 512);
         checks++;
         if ({cnt_sync_out, ch(1)} !== {ec, (c >= 3) ? 16'd20 : 16'd10}) begin
            errors++;
            $display("FAIL boundary_gain got cnt=%0d ch1=%0d exp cnt=%0d ch1=%0d",
                     cnt_sync_out, ch(1), ec, (c >= 3) ? 20 : 10);
         end
      end
      // A frame start with nothing pending keeps x2 despite the shadow holding x4.
      push(1'b1, 9'd0, 16'h0, 16'd10, 16'h0, 16'h0);
      coef_commit = 1'b1;
      push(1'b1, 9'd1, 16'h0, 16'd10, 16'h0, 16'h0);
      idle(2);
      checks++;
      if (ch(1) !== 16'd20) begin
         errors++;
         $display("FAIL no_pending_frame got ch1=%0d exp 20", ch(1));
      end
      // The applying boundary carries a fresh commit, so pending must stay set.
      coef_commit = 1'b1;
      push(1'b1, 9'd0, 16'h0, 16'd10, 16'h0, 16'h0);
      checks++;
      if (commit_pending !== 1'b1) begin
         errors++;
         $display("FAIL commit_rearm got %b exp 1", commit_pending);
      end
      idle(3);
      checks++;
      if (ch(1) !== 16'd40) begin
         errors++;
         $display("FAIL deferred_write got ch1=%0d exp 40", ch(1));
      end
      push(1'b1, 9'd0, 16'h0, 16'h0, 16'h0, 16'h0);
      idle(3);
   endtask

   task automatic test_rounding();
      logic [15:0] e0, e2;
`ifdef PRECISION_ADJ_ROUND_EN
      e0 = 16'd5;  e2 = 16'hFFFC;
`else
      e0 = 16'd4;  e2 = 16'hFFFB;
`endif
      wr(2'd0, 16'h0180);
      wr(2'd2, 16'h0180);
      coef_commit = 1'b1;
      idle(1);
      push(1'b1, 9'd0, 16'd3, 16'h0, 16'hFFFD, 16'h0);
      idle(3);
      checks++;
      if (ch(0) !== e0) begin
         errors++;
         $display("FAIL round_unsigned got ch0=%h exp %h", ch(0), e0);
      end
      checks++;
      if (ch(2) !== e2) begin
         errors++;
         $display("FAIL round_signed got ch2=%h exp %h", ch(2), e2);
      end
   endtask

   task automatic test_reset_mid();
      coef_commit = 1'b1;
      push(1'b1, 9'd7, 16'd100, 16'd100, 16'd100, 16'd100);
      push(1'b1, 9'd8, 16'd100, 16'd100, 16'd100, 16'd100);
      push(1'b1, 9'd9, 16'd100, 16'd100, 16'd100, 16'd100);
      rst = 1'b1;
      idle(1);
      checks++;
      if ({en_sync_out, data_out, commit_pending} !== '0) begin
         errors++;
         $display("FAIL mid_reset got en=%b data=%h pend=%b exp 0",
                  en_sync_out, data_out, commit_pending);
      end
      rst = 1'b0;
      push(1'b1, 9'd5, 16'd1000, 16'd1000, 16'd1000, 16'd1000);
      idle(2);
      checks++;
      if (en_sync_out !== 1'b0) begin
         errors++;
         $display("FAIL flushed_inflight got en=%b exp 0", en_sync_out);
      end
      idle(1);
      checks++;
      if ({en_sync_out, data_out} !== {1'b1, {4{16'd1000}}}) begin
         errors++;
         $display("FAIL unity_restored got en=%b data=%h exp en=1 all 03e8",
                  en_sync_out, data_out);
      end
   endtask

   initial begin
      test_reset();
      test_unsigned_sat();
      test_signed();
      test_commit_timing();
      test_rounding();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/precision_adj_nch.md
Name: precision_adj_nch

Overview:
Parametrised N-channel gain/precision adjust stage for the Stokes/spectral accumulation path. Each channel sample is multiplied by a per-channel fixed-point coefficient, then rounded, shifted and saturated back to the input width. Sync enable and bin counter are carried through with matching latency. Coefficients are double-buffered and take effect only at a frame boundary, so a spectrum never mixes old and new gains.

Parameters:
NCH, 4, number of channels
DW, 16, sample width per channel
CW, 16, coefficient width; unsigned; FRAC fractional bits
FRAC, 8, coefficient fractional bits; FRAC < CW, FRAC >= 1
CNT_W, 9, sync counter width
SIGNED_MASK, 4'b1100, bit n = 1 makes channel n two's-complement, otherwise unsigned

Ports:
clk  in  1  clock
rst  in  1  reset
coef_wr  in  1  write shadow coefficient
coef_addr  in  AW=max(1,clog2(NCH))  channel index for coef_wr
coef_data  in  CW  shadow coefficient value
coef_commit  in  1  arm transfer shadow->active at next frame start
commit_pending  out  1  commit armed, not yet applied
en_sync_in  in  1  sample-valid / sync enable
cnt_sync_in  in  CNT_W  bin counter
data_in  in  NCH*DW  channel n at [n*DW +: DW]
en_sync_out  out  1  delayed en_sync_in
cnt_sync_out  out  CNT_W  delayed cnt_sync_in
data_out  out  NCH*DW  adjusted samples, same packing
sat_flag  out  NCH  sticky per-channel saturation
sat_clr  in  1  clear all sat_flag bits

Behaviour:
- Reset: rst is synchronous, active-high, on clk. All pipeline registers, en_sync_out, cnt_sync_out, data_out, sat_flag and commit_pending go to 0. Shadow and active coefficients go to unity (1<<FRAC).
- Coefficient write: coef_wr=1 writes coef_data to shadow[coef_addr]. coef_addr >= NCH is ignored.
- Frame start: a cycle with en_sync_in=1 and cnt_sync_in==0.
- coef_commit=1 sets commit_pending. Repeated commits while pending have no further effect.
- At a frame start with commit_pending=1: active <= shadow for all channels, and commit_pending clears.
  - The frame-start sample itself already uses the new coefficients; stage 1 captures coefficients from shadow in that cycle.
  - A shadow write in the frame-start cycle is not included; the pre-write shadow value is used.
  - Shadow writes made after the commit but before the boundary are included.
- coef_commit in the same cycle as an applying frame start: the transfer happens, and pending remains set for the next boundary.
- Pipeline: free-running, fixed latency of 4 cycles; en/cnt delayed identically.
  - S1: register data and the selected coefficient.
  - S2: full product, DW+CW+1 bits. Signed channels use a signed sample × zero-extended coefficient; unsigned channels use unsigned × unsigned.
  - S3: arithmetic shift right by FRAC, with rounding per the optional feature.
  - S4: saturate to DW bits. Unsigned range is [0, 2^DW-1]. Signed range is [-2^(DW-1), 2^(DW-1)-1]. Register the result to data_out.
- sat_flag[n]: sets when S4 clamps channel n and en at S4 is 1. Data with en=0 still flows but does not set flags.
- sat_clr clears all flags. If a set and a clear for the same bit occur in one cycle, the set wins.
- en_sync_in=0 is not a stall. Outputs still update every cycle; consumers qualify with en_sync_out.
- Reset mid-operation: the in-flight samples are discarded, and en_sync_out is 0 on the cycle after rst.

Optional Feature:
PRECISION_ADJ_ROUND_EN defined: S3 adds 2^(FRAC-1) before the shift, giving round-half-up (toward +inf). Not defined: plain arithmetic shift (floor/truncate). Latency is 4 in both cases.

Test Plan:
- Reset defaults: deassert rst, drive ch0=1000 with en=1 and cnt=5 -> 4 cycles later en_sync_out=1, cnt_sync_out=5, ch0 out=1000 (unity 0x0100); commit_pending=0; sat_flag=0.
- Unsigned saturation: set ch0 coef 0x0400 (x4), commit, send frame start, then ch0=0x8000 -> out 0xFFFF and sat_flag[0]=1. Pulse sat_clr -> flag cleared. Input 0x1000 -> 0x4000.
- Signed range on ch3: coef 0x0200 (x2).
  - In 0xC000 -> 0x8000, no saturation.
  - In 0xBFFF -> 0x8000 with sat_flag[3]=1.
  - In 0x3FFF -> 0x7FFE.
- Commit timing: write ch1 coef 0x0200, pulse commit at cnt=100.
  - Ch1 remains x1 for cnt 101..511.
  - The sample at cnt=0 and all later samples are x2.
  - commit_pending drops in the cnt=0 cycle.
  - Also verify that a write on the boundary cycle is deferred to the next commit.
- Rounding: coef 0x0180 (1.5).
  - Unsigned ch0: in 3 -> 5 with ROUND_EN, 4 without.
  - Signed ch2: in -3 -> -4 with ROUND_EN, -5 without.
- Reset mid-stream: assert rst with 3 valid samples in flight -> the next cycle has data_out=0 and en_sync_out=0; coefficients are back to unity; commit_pending=0.
